fetch_sequencer: RTL and testbench

Multi-cycle instruction-fetch controller that owns the program counter and sequences reads of the 256 x 16-bit instruction memory. On a fetch request from the control unit it holds a stable address, waits a configurable memory latency, and latches the returned word into the instruction register. It then signals completion and advances or redirects the PC. It sits between the control FSM and instruction_memory.

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_pc_reg.sv | 50 +++++
 rtl/fetch_sequencer.sv | 93 +++++++++
 tb/tb_fetch_sequencer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and elaboration helpers for the instruction-fetch sequencer.
package fetch_pkg;

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

  localparam int DEF_MEM_DEPTH   = 256;
  localparam int DEF_MEM_LATENCY = 1;

  // Address mask for a power-of-two memory; the PC wraps modulo the depth.
  function automatic int pc_mask(input int depth);
    return depth - 1;
  endfunction

  // The latency counter must hold MEM_LATENCY itself, never less than one bit.
  function automatic int cnt_width(input int latency);
    return (latency < 1) ? 1 : $clog2(latency + 1);
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter with masked load, modulo increment and a deferred redirect
// that is captured while a fetch is in flight and applied when it completes.
module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int MEM_DEPTH = DEF_MEM_DEPTH,
  parameter int RESET_PC  = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_now,
  input  logic              load_defer,
  input  logic              advance,
  input  logic [ADDR_W-1:0] load_value,
  input  logic [ADDR_W-1:0] base,
  output logic [ADDR_W-1:0] pc
);

  localparam logic [ADDR_W-1:0] MASK = ADDR_W'(pc_mask(MEM_DEPTH));

  logic              pend_valid;
  logic [ADDR_W-1:0] pend_value;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order between blocks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc         <= ADDR_W'(RESET_PC);
      pend_valid <= 1'b0;
      pend_value <= '0;
    end else if (advance) begin
      // A redirect arriving on the completion edge wins over an older one.
      if (load_defer) begin
        pc <= load_value & MASK;
      end else if (pend_valid) begin
        pc <= pend_value;
      end else begin
        pc <= (base + ADDR_W'(1)) & MASK;
      end
      pend_valid <= 1'b0;
    end else if (load_defer) begin
      pend_valid <= 1'b1;
      pend_value <= load_value & MASK;
    end else if (load_now) begin
      pc <= load_value & MASK;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch controller: holds the address for MEM_LATENCY cycles,
// latches the returned word into ir and advances or redirects the PC.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int MEM_DEPTH   = DEF_MEM_DEPTH,
  parameter int MEM_LATENCY = DEF_MEM_LATENCY,
  parameter int RESET_PC    = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_value,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  output logic [DATA_W-1:0] ir,
  output logic              ir_valid,
  output logic              busy,
  output logic [ADDR_W-1:0] pc,
  output logic [15:0]       fetch_count
);

  localparam int CNT_W = cnt_width(MEM_LATENCY);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr_q;
  logic              last_wait;

  assign last_wait = (state == WAIT) && (cnt == CNT_W'(1));

  fetch_pc_reg #(
    .ADDR_W    (ADDR_W),
    .MEM_DEPTH (MEM_DEPTH),
    .RESET_PC  (RESET_PC)
  ) u_pc (
    .clk        (clk),
    .reset      (reset),
    .load_now   ((state == IDLE) && pc_load),
    .load_defer ((state == WAIT) && pc_load),
    .advance    (last_wait),
    .load_value (pc_load_value),
    .base       (addr_q),
    .pc         (pc)
  );

  // The PC only moves in IDLE or on the completion edge, so during WAIT it
  // equals addr_q and the memory address can come straight from the PC flop.
  assign imem_addr = pc;

  // NOTE: reset is asynchronous; every register is listed in the reset branch
  // so none of them keeps a stale value after an aborted fetch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      addr_q      <= ADDR_W'(RESET_PC);
      ir          <= '0;
      ir_valid    <= 1'b0;
      busy        <= 1'b0;
      fetch_count <= '0;
    end else begin
      ir_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (fetch_req && !pc_load) begin
            addr_q <= pc;
            cnt    <= CNT_W'(MEM_LATENCY);
            busy   <= 1'b1;
            state  <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == CNT_W'(1)) begin
            ir          <= imem_data;
            ir_valid    <= 1'b1;
            fetch_count <= fetch_count + 16'd1;
            busy        <= 1'b0;
            cnt         <= '0;
            state       <= IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench: stimulus pushes expected fetch results, a negedge monitor
// pops and compares them whenever ir_valid is seen.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset, fetch_req, pc_load;
  logic [15:0] pc_load_value, imem_addr, imem_data, ir, pc, fetch_count;
  logic        ir_valid, busy;

  logic        reset3, fetch_req3;
  logic [15:0] imem_addr3, imem_data3, ir3, pc3, fetch_count3;
  logic        ir_valid3, busy3;

  logic [15:0] mem [256];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    int          cyc;
    logic [15:0] ir;
    logic [15:0] pc;
    logic [15:0] cnt;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign imem_data  = mem[imem_addr[7:0]];
  assign imem_data3 = mem[imem_addr3[7:0]];

  fetch_sequencer #(.MEM_LATENCY(1)) dut (
    .clk(clk), .reset(reset), .fetch_req(fetch_req), .pc_load(pc_load),
    .pc_load_value(pc_load_value), .imem_addr(imem_addr), .imem_data(imem_data),
    .ir(ir), .ir_valid(ir_valid), .busy(busy), .pc(pc), .fetch_count(fetch_count)
  );

  fetch_sequencer #(.MEM_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset3), .fetch_req(fetch_req3), .pc_load(1'b0),
    .pc_load_value(16'h0000), .imem_addr(imem_addr3), .imem_data(imem_data3),
    .ir(ir3), .ir_valid(ir_valid3), .busy(busy3), .pc(pc3), .fetch_count(fetch_count3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int c, input logic [15:0] i, input logic [15:0] p, input logic [15:0] n);
    exp_t e;
    e.cyc = c; e.ir = i; e.pc = p; e.cnt = n;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    check("reset_pc", pc, 16'h0000);
    check("reset_ir", ir, 16'h0000);
    check("reset_busy", busy, 0);
    check("reset_count", fetch_count, 16'h0000);
    check("reset_imem_addr", imem_addr, 16'h0000);
    tick();
    reset = 1'b0;
  endtask

  // Monitor: every ir_valid cycle must match the oldest expected fetch.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (ir_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_ir_valid", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("ir_valid_cycle", cyc, e.cyc);
          check("ir_value", ir, e.ir);
          check("pc_after_fetch", pc, e.pc);
          check("fetch_count", fetch_count, e.cnt);
        end
      end else if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
        check("missing_ir_valid", cyc, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'hC000 | 16'(i);
    mem[0]   = 16'h029A;
    mem[5]   = 16'h5A5A;
    mem[48]  = 16'h3C3C;
    mem[255] = 16'hBEEF;
    fetch_req = 0; pc_load = 0; pc_load_value = 0; fetch_req3 = 0;
    reset3 = 1'b1;
    #1;
    do_reset();
    reset3 = 1'b0;

    // Single fetch from RESET_PC.
    fetch_req = 1;
    push(cyc + 2, 16'h029A, 16'h0001, 16'h0001);
    @(negedge clk);
    check("t1_addr_c0", imem_addr, 16'h0000);
    tick();
    fetch_req = 0;
    @(negedge clk);
    check("t1_addr_c1", imem_addr, 16'h0000);
    check("t1_busy_c1", busy, 1);
    tick();
    tick();
    @(negedge clk);
    check("t1_ir_hold", ir, 16'h029A);
    tick();

    // Back-to-back fetches with fetch_req held high.
    do_reset();
    mem[0] = 16'hA000; mem[1] = 16'hA001; mem[2] = 16'hA002; mem[3] = 16'hA003;
    for (int i = 0; i < 9; i++) begin
      fetch_req = (i < 8);
      if (i < 8 && i % 2 == 0)
        push(cyc + 2, 16'hA000 | 16'(i / 2), 16'(i / 2 + 1), 16'(i / 2 + 1));
      @(negedge clk);
      check("t2_busy", busy, (i % 2 == 1));
      tick();
    end
    fetch_req = 0;
    @(negedge clk);
    check("t2_pc_final", pc, 16'h0004);
    tick();

    // Masked load to 255, then fetch and wrap.
    do_reset();
    pc_load = 1; pc_load_value = 16'h01FF;
    tick();
    pc_load = 0;
    @(negedge clk);
    check("t3_pc_masked", pc, 16'h00FF);
    check("t3_addr_masked", imem_addr, 16'h00FF);
    fetch_req = 1;
    push(cyc + 2, 16'hBEEF, 16'h0000, 16'h0001);
    tick();
    fetch_req = 0;
    tick();
    tick();
    @(negedge clk);
    check("t3_pc_wrap", pc, 16'h0000);

    // Redirect during WAIT replaces the increment.
    do_reset();
    pc_load = 1; pc_load_value = 16'h0005;
    tick();
    pc_load = 0;
    fetch_req = 1;
    push(cyc + 2, 16'h5A5A, 16'h0040, 16'h0001);
    tick();
    fetch_req = 0;
    pc_load = 1; pc_load_value = 16'h0040;
    @(negedge clk);
    check("t4_addr_held", imem_addr, 16'h0005);
    tick();
    pc_load = 0;
    tick();
    @(negedge clk);
    check("t4_pc_redirect", pc, 16'h0040);

    // pc_load wins over fetch_req in IDLE.
    do_reset();
    pc_load = 1; pc_load_value = 16'h0030; fetch_req = 1;
    tick();
    pc_load = 0; fetch_req = 0;
    @(negedge clk);
    check("t5_busy_idle", busy, 0);
    check("t5_pc_loaded", pc, 16'h0030);
    fetch_req = 1;
    push(cyc + 2, 16'h3C3C, 16'h0031, 16'h0001);
    tick();
    fetch_req = 0;
    tick();
    tick();

    // MEM_LATENCY=3: full fetch, then reset in the second WAIT cycle.
    fetch_req3 = 1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("t6_valid3", ir_valid3, (k == 4));
      check("t6_busy3", busy3, (k >= 1 && k <= 3));
      tick();
      fetch_req3 = 0;
    end
    check("t6_ir3", ir3, 16'hA000);
    check("t6_pc3", pc3, 16'h0001);
    fetch_req3 = 1;
    tick();
    fetch_req3 = 0;
    tick();
    #2;
    check("t6_busy3_pre", busy3, 1);
    reset3 = 1'b1;
    #1;
    check("t6_rst_pc3", pc3, 16'h0000);
    check("t6_rst_busy3", busy3, 0);
    check("t6_rst_count3", fetch_count3, 16'h0000);
    tick();
    tick();
    reset3 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t6_no_valid3", ir_valid3, 0);
      tick();
    end

    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
